// File: rtl/rx_fifo_settings.sv
// Receive-path buffer: 4096 x 16 synchronous FIFO with registered status
// flags, plus one 32-bit settings register loaded from the serial bus.
module rx_fifo_settings #(
    parameter logic [6:0] SR_ADDR    = 7'd0,
    parameter int         DEPTH_LOG2 = 12,
    parameter int         PKT_THRESH = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            serial_addr,
    input  logic [31:0]           serial_data,
    input  logic                  serial_strobe,
    output logic [31:0]           sr_out,
    input  logic [15:0]           data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [15:0]           q,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2-1:0] usedw,
    output logic                  pkt_rdy
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH   = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0] THRESH  = CW'(PKT_THRESH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [15:0]           mem [0:(1 << DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  do_wr;
    logic                  do_rd;

    // Acceptance uses the registered flags, so no input reaches an output.
    assign do_wr = wrreq & ~full;
    assign do_rd = rdreq & ~empty;
    assign usedw = count[DEPTH_LOG2-1:0];

    always_comb begin
        count_nxt = count;
        unique case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // RAM contents are not cleared; reset only blocks a same-cycle write.
    always_ff @(posedge clock) begin
        if (!reset && do_wr)
            mem[wr_ptr] <= data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_out  <= '0;
            q       <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            pkt_rdy <= 1'b0;
        end else begin
            if (serial_strobe && serial_addr == SR_ADDR)
                sr_out <= serial_data;
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) begin
                q      <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count   <= count_nxt;
            empty   <= (count_nxt == '0);
            full    <= (count_nxt == DEPTH);
            pkt_rdy <= (count_nxt >= THRESH) || (count_nxt == DEPTH);
        end
    end

endmodule

// File: tb/tb_rx_fifo_settings.sv
// Scoreboard bench for rx_fifo_settings: expected words queued on write,
// popped and compared when the read data appears on q.
module tb_rx_fifo_settings;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic [31:0] sr_out;
    logic [15:0] data = '0;
    logic        wrreq = 1'b0;
    logic        rdreq = 1'b0;
    logic [15:0] q;
    logic        empty;
    logic        full;
    logic [11:0] usedw;
    logic        pkt_rdy;

    int          errors = 0;
    int          checks = 0;
    int          mcount = 0;
    logic [15:0] last_q = '0;
    logic [15:0] sb[$];

    rx_fifo_settings dut (
        .clock(clock),
        .reset(reset),
        .serial_addr(serial_addr),
        .serial_data(serial_data),
        .serial_strobe(serial_strobe),
        .sr_out(sr_out),
        .data(data),
        .wrreq(wrreq),
        .rdreq(rdreq),
        .q(q),
        .empty(empty),
        .full(full),
        .usedw(usedw),
        .pkt_rdy(pkt_rdy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        sb.delete();
        mcount = 0;
        last_q = '0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".usedw"}, 32'(usedw), 32'(mcount % 4096));
        check({tag, ".empty"}, 32'(empty), 32'(mcount == 0));
        check({tag, ".full"}, 32'(full), 32'(mcount == 4096));
        check({tag, ".pkt_rdy"}, 32'(pkt_rdy), 32'(mcount >= 256));
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r);
        bit          acc_w;
        bit          acc_r;
        logic [15:0] exp_q;
        acc_w = w && (mcount != 4096);
        acc_r = r && (mcount != 0);
        exp_q = last_q;
        if (acc_r) exp_q = sb.pop_front();
        if (acc_w) sb.push_back(d);
        wrreq = w;
        data  = d;
        rdreq = r;
        tick();
        wrreq = 1'b0;
        rdreq = 1'b0;
        mcount = mcount + int'(acc_w) - int'(acc_r);
        if (acc_r) begin
            last_q = exp_q;
            check("q", 32'(q), 32'(exp_q));
        end
    endtask

    initial begin
        do_reset();
        check("rst.sr_out", sr_out, 32'h0);
        check("rst.q", 32'(q), 32'h0);
        check_flags("rst");

        serial_strobe = 1'b1;
        serial_addr   = 7'd0;
        serial_data   = 32'h0000_1234;
        tick();
        serial_strobe = 1'b0;
        check("sr.load", sr_out, 32'h0000_1234);
        serial_strobe = 1'b1;
        serial_addr   = 7'd1;
        serial_data   = 32'hFFFF_FFFF;
        tick();
        serial_strobe = 1'b0;
        check("sr.other_addr", sr_out, 32'h0000_1234);
        serial_addr = 7'd0;
        serial_data = 32'hCAFE_F00D;
        tick();
        check("sr.no_strobe", sr_out, 32'h0000_1234);
        do_reset();
        check("sr.reset", sr_out, 32'h0);

        step(1, 16'hA5A5, 0);
        step(1, 16'h0001, 0);
        step(1, 16'hFFFF, 0);
        check_flags("basic3");
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1);
        check_flags("basic_drained");

        for (int i = 0; i < 255; i++) step(1, 16'(i + 100), 0);
        check_flags("thr255");
        step(1, 16'h7777, 0);
        check_flags("thr256");
        step(0, 16'h0, 1);
        check_flags("thr_after_read");
        do_reset();

        for (int i = 0; i < 4096; i++) step(1, 16'(i), 0);
        check_flags("full");
        step(1, 16'hDEAD, 0);
        check_flags("overflow");
        for (int i = 0; i < 4096; i++) step(0, 16'h0, 1);
        check_flags("full_drained");

        step(0, 16'h0, 1);
        check("underflow.q", 32'(q), 32'(last_q));
        check_flags("underflow");

        for (int i = 0; i < 10; i++) step(1, 16'(16'h5000 + i), 0);
        for (int i = 0; i < 5000; i++) step(1, 16'(i * 7 + 3), 1);
        check_flags("simul");
        for (int i = 0; i < 10; i++) step(0, 16'h0, 1);
        check_flags("simul_drained");

        for (int i = 0; i < 300; i++) step(1, 16'(i ^ 16'h3C3C), 0);
        check_flags("pre_reset300");
        reset = 1'b1;
        wrreq = 1'b1;
        rdreq = 1'b1;
        data  = 16'hBEEF;
        tick();
        reset = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        sb.delete();
        mcount = 0;
        last_q = '0;
        check("midrst.q", 32'(q), 32'h0);
        check_flags("midrst");
        tick();
        check_flags("midrst_hold");
        step(0, 16'h0, 1);
        check("midrst.q_hold", 32'(q), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_fifo_settings.md
Name: rx_fifo_settings

Overview:
Single-clock receive-path buffer for the DSP-to-USB data path. It combines a 4096 x 16 synchronous FIFO, with level, empty, full and packet-ready status, and a 32-bit settings register. The settings register is loaded from the serial control bus (7-bit address, 32-bit data, strobe). It sits between the RX sample multiplexer and the USB read logic and holds the RX format word (bypass_hb, want_q, bitwidth, bitshift) that upstream logic decodes.

Parameters:
SR_ADDR, 0, serial-bus address (0..127) the settings register responds to
DEPTH_LOG2, 12, log2 of FIFO depth; depth = 4096 words
PKT_THRESH, 256, word count at or above which pkt_rdy asserts (one 512-byte USB packet)

Ports:
clock  in  1  single clock; everything is sampled on the rising edge
reset  in  1  synchronous, active-high; clears FIFO state and the settings register
serial_addr  in  7  settings bus address
serial_data  in  32  settings bus data
serial_strobe  in  1  settings bus write strobe
sr_out  out  32  settings register contents
data  in  16  FIFO write data
wrreq  in  1  write request
rdreq  in  1  read request
q  out  16  FIFO read data
empty  out  1  FIFO holds 0 words
full  out  1  FIFO holds 4096 words
usedw  out  12  word count modulo 4096 (reads 0 when full; use the full flag to distinguish)
pkt_rdy  out  1  word count >= PKT_THRESH, or full

Behaviour:
- Reset is synchronous and active-high on clock. On reset:
  - sr_out=0, q=0, empty=1, full=0, usedw=0, pkt_rdy=0.
  - Read and write pointers clear to 0; stored RAM contents need not clear.
  - Reset has priority over every other input in the same cycle.
  - Reset mid-operation discards all buffered words.
- Settings register:
  - On a rising edge with serial_strobe=1 and serial_addr==SR_ADDR, sr_out <= serial_data; visible the next cycle.
  - Any other address, or strobe low: sr_out holds.
  - No read-back path.
- FIFO write:
  - Accepted when wrreq=1 and full=0, using the registered full of the current cycle.
  - data is stored at the write pointer; the pointer increments, wrapping 4095 -> 0.
  - wrreq while full is ignored: no data change, no error flag.
- FIFO read (normal, non-show-ahead mode):
  - Accepted when rdreq=1 and empty=0.
  - q is loaded with the word at the read pointer at that edge, so it is valid the cycle after rdreq.
  - The read pointer increments and wraps.
  - rdreq while empty is ignored and q holds its last value.
  - q also holds whenever no read is accepted.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
  - When empty, only the write is accepted.
  - When full, only the read is accepted.
- Count and flags:
  - Internal count is 13 bits, 0..4096, updated in the same edge as the accepted operations.
  - usedw = count[11:0], empty = (count==0), full = (count==4096), pkt_rdy = (count >= PKT_THRESH).
  - All flags are registered and reflect the state after the edge, so there is one cycle of latency from request to flag change.
- Data order is strictly first-in first-out across pointer wrap.
- No combinational path from any input to any output.

Test Plan:
- Settings load: reset, then strobe with addr=SR_ADDR and data=32'h0000_1234 -> sr_out=32'h0000_1234 next cycle. Strobe with addr=SR_ADDR+1, data=32'hFFFF_FFFF -> sr_out unchanged. Reset -> sr_out=0.
- Basic FIFO: write 16'hA5A5, 16'h0001, 16'hFFFF on consecutive cycles -> usedw=3, empty=0. Three rdreq cycles -> q=A5A5, 0001, FFFF, each one cycle after its rdreq. Then empty=1, usedw=0.
- Packet threshold: write 255 words -> pkt_rdy=0. The 256th write -> pkt_rdy=1 the following cycle. One read -> pkt_rdy=0.
- Full and overflow: write 4096 words (value = index) -> full=1, usedw=0, pkt_rdy=1. An extra write of 16'hDEAD is dropped. Reading 4096 words returns 0..4095 in order, never DEAD; then empty=1.
- Underflow and simultaneous access: rdreq on empty -> q holds, usedw stays 0. With 10 words held, wrreq+rdreq together for 5000 cycles -> usedw stays 10 and output order is preserved across pointer wrap.
- Mid-operation reset: with 300 words stored, assert reset together with wrreq and rdreq -> next cycle empty=1, usedw=0, pkt_rdy=0, q=0, and no word is written.
